poly_acc_buf: RTL and testbench

- Streaming polynomial accumulator that sits directly downstream of mod_add.
- Sums NUM coefficient-wise 256-coefficient polynomials mod Q=3329, e.g. accumulating the k products of the A·s / Aᵀ·r matrix-vector step in ML-KEM.
- Stores the running sum in an internal 256x12 buffer.
- Streams the reduced result out over a valid/ready interface.
- Uses one mod_add instance for the read-add-writeback path.

---
 rtl/poly_acc_buf_if.sv | 33 +++
 rtl/poly_acc_buf.sv | 183 ++++++++++++++++++
 tb/tb_poly_acc_buf.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/poly_acc_buf_if.sv
// Coefficient stream bundle for poly_acc_buf: the input stream from mod_add
// and the reduced result stream toward the consumer.
// slave  : the accumulator's view.
// master : the upstream/downstream environment's view.
interface poly_acc_buf_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [11:0] in_coeff_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [11:0] out_coeff_o;
    logic        out_last_o;

    modport slave (
        input  in_valid_i,
        input  in_coeff_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_coeff_o,
        output out_last_o
    );

    modport master (
        output in_valid_i,
        output in_coeff_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_coeff_o,
        input  out_last_o
    );
endinterface

// File: rtl/poly_acc_buf.sv
// poly_acc_buf: streaming accumulator that adds num_terms polynomials of
// N_COEFF coefficients each, mod 3329. The running sum lives in an internal
// buffer, and the result is streamed out over valid/ready.
//
// Optional build macro POLY_ACC_RANGE_CHECK_EN adds a sticky err_o output.
// It flags any accepted coefficient >= 3329, and folds that coefficient back
// into range by subtracting 3329 once.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a start with a legal term count
// ACCUM  | accepting input beats, read-add-writeback into the buffer
// DRAIN  | streaming the buffer out, one coefficient per handshake

// Single conditional-subtract modular adder, for operands already in 0..3328.
module mod_add (
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic [11:0] sum
);
    localparam logic [12:0] Q = 13'd3329;

    logic [12:0] raw;

    // add, then fold back once if the sum reached the modulus
    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        sum = (raw >= Q) ? 12'(raw - Q) : raw[11:0];
    end
endmodule

module poly_acc_buf #(
    parameter int N_COEFF   = 256,  // must be a power of 2 so idx wraps by overflow
    parameter int MAX_TERMS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [2:0]          num_terms_i,
    poly_acc_buf_if.slave       s,
    output logic                busy_o,
    output logic                done_o
`ifdef POLY_ACC_RANGE_CHECK_EN
    ,
    output logic                err_o
`endif
);
    localparam int IDX_W = $clog2(N_COEFF);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEFF - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [2:0]       term_q;
    logic [2:0]       num_terms_q;
    logic             done_q;
    logic [11:0]      coeff_buf [N_COEFF];

    logic             start_ok;
    logic             in_hs;
    logic             out_hs;
    logic             idx_last;
    logic             term_last;
    logic [11:0]      in_eff;
    logic [11:0]      rd_val;
    logic [11:0]      acc_sum;
    logic [11:0]      wr_val;

    assign start_ok  = start_i && (num_terms_i != 3'd0) && (num_terms_i <= 3'(MAX_TERMS));
    assign in_hs     = s.in_valid_i && (state_q == ACCUM);
    assign out_hs    = s.out_ready_i && (state_q == DRAIN);
    assign idx_last  = (idx_q == LAST_IDX);
    assign term_last = (term_q == num_terms_q - 3'd1);

`ifdef POLY_ACC_RANGE_CHECK_EN
    logic in_over;

    // fold a single out-of-range excursion back into 0..3328
    always_comb begin
        in_over = (s.in_coeff_i >= 12'd3329);
        in_eff  = in_over ? (s.in_coeff_i - 12'd3329) : s.in_coeff_i;
    end

    // sticky error, cleared only by reset or an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (state_q == IDLE && start_ok) begin
            err_o <= 1'b0;
        end else if (in_hs && in_over) begin
            err_o <= 1'b1;
        end
    end
`else
    assign in_eff = s.in_coeff_i;
`endif

    // One read port serves both the accumulate path and the drain path.
    // The two never overlap, because ACCUM and DRAIN are exclusive.
    assign rd_val = coeff_buf[idx_q];

    mod_add u_mod_add (
        .a   (rd_val),
        .b   (in_eff),
        .sum (acc_sum)
    );

    // The first term overwrites the buffer, so contents left from before
    // reset never leak into a result.
    assign wr_val = (term_q == 3'd0) ? in_eff : acc_sum;

    // buffer write-back; no reset needed since term 0 rewrites every entry
    always_ff @(posedge clk) begin
        if (in_hs) begin
            coeff_buf[idx_q] <= wr_val;
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = ACCUM;
            ACCUM:   if (in_hs && idx_last && term_last) state_d = DRAIN;
            DRAIN:   if (out_hs && idx_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Index/term counters and done pulse. idx wraps to 0 on its own at
    // N_COEFF-1, which also leaves it at 0 on entry to DRAIN and to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            term_q      <= 3'd0;
            num_terms_q <= 3'd0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q == DRAIN) && out_hs && idx_last;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        idx_q       <= '0;
                        term_q      <= 3'd0;
                        num_terms_q <= num_terms_i;
                    end
                end
                ACCUM: begin
                    if (in_hs) begin
                        idx_q <= idx_q + 1'b1;
                        if (idx_last) begin
                            term_q <= term_q + 3'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s.in_ready_o  = (state_q == ACCUM);
    assign s.out_valid_o = (state_q == DRAIN);
    assign s.out_coeff_o = (state_q == DRAIN) ? rd_val : 12'd0;
    assign s.out_last_o  = (state_q == DRAIN) && idx_last;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
endmodule

// File: tb/tb_poly_acc_buf.sv
// Bench for poly_acc_buf: randomized and patterned polynomial streams are
// checked against a plain-arithmetic sum-mod-3329 model. The expected result
// beats are queued at stimulus time and popped by an independent monitor.
module tb_poly_acc_buf;
    localparam int N = 256;
    localparam int Q = 3329;

    typedef struct packed {
        logic [11:0] c;
        logic        last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [2:0] num_terms_i;
    logic       busy_o;
    logic       done_o;
`ifdef POLY_ACC_RANGE_CHECK_EN
    logic       err_o;
`endif

    poly_acc_buf_if io ();

    poly_acc_buf #(.N_COEFF(N), .MAX_TERMS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .num_terms_i (num_terms_i),
        .s           (io),
        .busy_o      (busy_o),
`ifdef POLY_ACC_RANGE_CHECK_EN
        .err_o       (err_o),
`endif
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   in_bubble = 0;
    int   out_bubble = 0;
    exp_t exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int gen(input int pat, input int t, input int i);
        case (pat)
            0:       return i;
            1:       return Q - 1;
            2:       return (i * 7 + t * 1000) % Q;
            3:       return int'($urandom_range(Q - 1));
            4:       return 5;
            5:       return (i == 3) ? 3330 : int'($urandom_range(Q - 1));
            default: return 0;
        endcase
    endfunction

    function automatic int eff(input int c);
        return (c >= Q) ? c - Q : c;
    endfunction

    // downstream ready, optionally with random bubbles
    initial begin
        io.out_ready_i = 1'b1;
        forever begin
            @(negedge clk);
            io.out_ready_i = (out_bubble == 0) || ($urandom_range(99) >= out_bubble);
        end
    end

    // monitor: checks stall stability and pops the scoreboard on each output handshake
    initial begin
        logic        stalled;
        logic [11:0] held_c;
        logic        held_l;
        exp_t        e;
        stalled = 1'b0;
        held_c  = 12'd0;
        held_l  = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall_valid", io.out_valid_o, 1);
                    chk("stall_coeff", io.out_coeff_o, held_c);
                    chk("stall_last", io.out_last_o, held_l);
                end
                if (io.out_valid_o && io.out_ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_beat: got coeff %0d, expected no beat", io.out_coeff_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_coeff", io.out_coeff_o, e.c);
                        chk("out_last", io.out_last_o, e.last);
                    end
                    stalled = 1'b0;
                end else if (io.out_valid_o) begin
                    stalled = 1'b1;
                    held_c  = io.out_coeff_o;
                    held_l  = io.out_last_o;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    // called at a negedge; returns at the negedge after the accepting posedge
    task automatic send_beat(input int c);
        int guard;
        guard = 0;
        while (in_bubble > 0 && $urandom_range(99) < in_bubble) begin
            io.in_valid_i = 1'b0;
            @(negedge clk);
        end
        io.in_valid_i = 1'b1;
        io.in_coeff_i = 12'(c);
        while (!io.in_ready_o && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_timeout", io.in_ready_o, 1);
        @(negedge clk);
        io.in_valid_i = 1'b0;
    endtask

    // abort_after < 0: full run; otherwise reset after that many input beats
    task automatic run(input int nt, input int pat, input int abort_after);
        int   c [4][N];
        int   sum;
        int   beats;
        int   waited;
        logic bad_seen;
        bad_seen = 1'b0;
        for (int t = 0; t < 4; t++)
            for (int i = 0; i < N; i++)
                c[t][i] = gen(pat, t, i);
        if (abort_after < 0) begin
            for (int i = 0; i < N; i++) begin
                sum = 0;
                for (int t = 0; t < nt; t++) sum += eff(c[t][i]);
                exp_q.push_back('{c: 12'(sum % Q), last: (i == N - 1)});
            end
        end
        start_i     = 1'b1;
        num_terms_i = 3'(nt);
        @(negedge clk);
        start_i     = 1'b0;
        chk("busy_after_start", busy_o, 1);
`ifdef POLY_ACC_RANGE_CHECK_EN
        chk("err_clear_on_start", err_o, 0);
`endif
        beats = 0;
        for (int t = 0; t < nt; t++) begin
            for (int i = 0; i < N; i++) begin
                if (abort_after >= 0 && beats == abort_after) begin
                    rst = 1'b1;
                    @(negedge clk);
                    chk("abort_busy", busy_o, 0);
                    chk("abort_in_ready", io.in_ready_o, 0);
                    chk("abort_out_valid", io.out_valid_o, 0);
                    chk("abort_done", done_o, 0);
                    rst = 1'b0;
                    @(negedge clk);
                    return;
                end
                send_beat(c[t][i]);
                beats++;
`ifdef POLY_ACC_RANGE_CHECK_EN
                if (c[t][i] >= Q) bad_seen = 1'b1;
                chk("err_sticky", err_o, bad_seen);
`endif
            end
        end
        chk("valid_after_last_in", io.out_valid_o, 1);
        chk("ready_low_in_drain", io.in_ready_o, 0);
        waited = 0;
        while (!done_o && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        chk("done_seen", done_o, 1);
        chk("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", done_o, 0);
        chk("busy_after_done", busy_o, 0);
    endtask

    initial begin
        rst           = 1'b1;
        start_i       = 1'b0;
        num_terms_i   = 3'd0;
        io.in_valid_i = 1'b0;
        io.in_coeff_i = 12'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_in_ready", io.in_ready_o, 0);
        chk("rst_out_valid", io.out_valid_o, 0);
        chk("rst_out_last", io.out_last_o, 0);
`ifdef POLY_ACC_RANGE_CHECK_EN
        chk("rst_err", err_o, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run(1, 0, -1);
        run(2, 1, -1);
        run(4, 2, -1);
        in_bubble  = 50;
        out_bubble = 50;
        run(4, 2, -1);
        run(3, 3, -1);
        in_bubble  = 0;
        out_bubble = 0;
        run(2, 3, N + 100);
        run(1, 4, -1);

        start_i     = 1'b1;
        num_terms_i = 3'd0;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        chk("start_zero_ignored", busy_o, 0);
        start_i     = 1'b1;
        num_terms_i = 3'd5;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        chk("start_five_ignored", busy_o, 0);

`ifdef POLY_ACC_RANGE_CHECK_EN
        run(1, 5, -1);
        run(1, 3, -1);
`endif
        in_bubble  = 30;
        out_bubble = 70;
        run(2, 3, -1);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
